// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding, opcode and branch-condition constants
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam logic [1:0] OP_BRANCH = 2'd2;

    localparam logic [1:0] COND_EQ = 2'd0;
    localparam logic [1:0] COND_GT = 2'd1;
    localparam logic [1:0] COND_LT = 2'd2;

    // Opcode lives in the two low instruction bits
    function automatic logic is_branch(input logic [1:0] opcode);
        return opcode == OP_BRANCH;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-fetch and datapath handshake bundle
interface pc_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) ();

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               exec_start;
    logic               exec_done;
    logic [INSTR_W-1:0] alu_result;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, exec_start,
        input  imem_ack, imem_data, exec_done, alu_result
    );

    // Memory / datapath side
    modport slave (
        input  imem_req, imem_addr, exec_start,
        output imem_ack, imem_data, exec_done, alu_result
    );

endinterface

// File: rtl/pc_sequencer_branch_eval.sv
// rtl/pc_sequencer_branch_eval.sv - combinational branch condition and next-pc selection
module branch_eval
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic [INSTR_W-1:0] last_result,
    output logic [PC_W-1:0]    next_pc,
    output logic               taken
);

    logic       cond_hit;
    logic [7:0] target;
    logic       unused_hi_bits;

    assign unused_hi_bits = ^instr[INSTR_W-1:12];

    // Condition field instr[3:2] compares the whole last result; code 3 never matches
    always_comb begin
        cond_hit = 1'b0;
        case (instr[3:2])
            COND_EQ: cond_hit = (last_result == INSTR_W'(0));
            COND_GT: cond_hit = (last_result == INSTR_W'(1));
            COND_LT: cond_hit = (last_result == INSTR_W'(2));
            default: cond_hit = 1'b0;
        endcase
        taken   = is_branch(instr[1:0]) && cond_hit;
        target  = instr[11:4];
        next_pc = taken ? PC_W'(target) : pc + PC_W'(1);
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/exec/update sequencer; PC_SEQUENCER_STEP_EN adds single-step input
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
`ifdef PC_SEQUENCER_STEP_EN
    input  logic               step,
`endif
    pc_sequencer_if.master     bus,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               branch_taken,
    output logic [15:0]        retire_cnt
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] last_result_q, last_result_d;
    logic [15:0]        retire_cnt_q, retire_cnt_d;
    logic               exec_first_q, exec_first_d;

    logic [PC_W-1:0]    next_pc;
    logic               taken;
    logic               go;
    logic               stay_stepping;

`ifdef PC_SEQUENCER_STEP_EN
    assign go            = run && step;
    assign stay_stepping = 1'b1;
`else
    assign go            = run;
    assign stay_stepping = 1'b0;
`endif

    branch_eval #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_branch_eval (
        .pc          (pc_q),
        .instr       (instr_q),
        .last_result (last_result_q),
        .next_pc     (next_pc),
        .taken       (taken)
    );

    // State and architectural registers; reset wins over every handshake input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            last_result_q <= '0;
            retire_cnt_q  <= '0;
            exec_first_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            last_result_q <= last_result_d;
            retire_cnt_q  <= retire_cnt_d;
            exec_first_q  <= exec_first_d;
        end
    end

    // Next-state: branches skip EXEC; stray ack/done in other states are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (go) state_d = ST_FETCH;
            ST_FETCH:  if (bus.imem_ack)
                           state_d = is_branch(bus.imem_data[1:0]) ? ST_UPDATE : ST_EXEC;
            ST_EXEC:   if (bus.exec_done) state_d = ST_UPDATE;
            ST_UPDATE: state_d = (run && !stay_stepping) ? ST_FETCH : ST_IDLE;
        endcase
    end

    // Register updates: instr on fetch, last_result only in EXEC, pc/retire in UPDATE
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        last_result_d = last_result_q;
        retire_cnt_d  = retire_cnt_q;
        exec_first_d  = (state_q == ST_FETCH);
        if (state_q == ST_FETCH && bus.imem_ack) instr_d = bus.imem_data;
        if (state_q == ST_EXEC && bus.exec_done) last_result_d = bus.alu_result;
        if (state_q == ST_UPDATE) begin
            pc_d         = next_pc;
            retire_cnt_d = retire_cnt_q + 16'd1;
        end
    end

    // Outputs: pulses are forced low while reset is held
    always_comb begin
        bus.imem_req   = !reset && (state_q == ST_FETCH);
        bus.imem_addr  = pc_q;
        bus.exec_start = !reset && (state_q == ST_EXEC) && exec_first_q;
        branch_taken   = !reset && (state_q == ST_UPDATE) && taken;
        instr          = instr_q;
        pc             = pc_q;
        retire_cnt     = retire_cnt_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with directed instruction vectors
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
`ifdef PC_SEQUENCER_STEP_EN
    logic        step = 1'b1;
`endif
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        branch_taken;
    logic [15:0] retire_cnt;

    pc_sequencer_if #(.PC_W(8), .INSTR_W(16)) bus ();

    pc_sequencer #(.PC_W(8), .INSTR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
`ifdef PC_SEQUENCER_STEP_EN
        .step         (step),
`endif
        .bus          (bus.master),
        .instr        (instr),
        .pc           (pc),
        .branch_taken (branch_taken),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ret;
        logic        tk;
        int          starts;
        logic [15:0] instr;
    } exp_t;

    typedef struct {
        logic [15:0] word;
        logic [15:0] alu;
        int          ack_dly;
        int          exec_dly;
        bit          noise;
        bit          drop;
        logic [7:0]  pc;
        logic [15:0] ret;
        bit          tk;
    } vec_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!bus.imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.imem_req;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        while (!bus.exec_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.exec_start;
    endtask

    // Drive one instruction through fetch and (for non-branches) exec; push its retirement
    task automatic issue(input vec_t v);
        exp_t e;
        bit   ok;
        bit   br;
        br       = (v.word[1:0] == 2'd2);
        e.pc     = v.pc;
        e.ret    = v.ret;
        e.tk     = v.tk;
        e.starts = br ? 0 : 1;
        e.instr  = v.word;
        exp_q.push_back(e);
        wait_req(ok);
        if (!ok) begin
            timeout_fail("wait_imem_req");
            return;
        end
        for (int i = 0; i < v.ack_dly; i++) begin
            if (v.noise) begin
                bus.exec_done  = 1'b1;
                bus.alu_result = 16'h0001;
            end
            @(negedge clk);
        end
        bus.exec_done = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = v.word;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'h0000;
        if (!br) begin
            wait_start(ok);
            if (!ok) begin
                timeout_fail("wait_exec_start");
                return;
            end
            for (int i = 0; i < v.exec_dly; i++) begin
                if (v.noise) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = 16'hFFF2;
                end
                if (v.drop) run = 1'b0;
                @(negedge clk);
            end
            bus.imem_ack   = 1'b0;
            bus.imem_data  = 16'h0000;
            bus.exec_done  = 1'b1;
            bus.alu_result = v.alu;
            @(negedge clk);
            bus.exec_done  = 1'b0;
        end
    endtask

    // Monitor: count exec_start/branch_taken between retirements and compare on each retirement
    initial begin
        logic [15:0] prev_ret;
        int          starts;
        logic        tk;
        exp_t        e;
        prev_ret = '0;
        starts   = 0;
        tk       = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !mon_en) begin
                prev_ret = retire_cnt;
                starts   = 0;
                tk       = 1'b0;
            end else begin
                if (bus.exec_start) starts++;
                if (retire_cnt !== prev_ret) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_retire actual=%0h required=none", retire_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("r%0d_pc", e.ret), pc, e.pc);
                        check($sformatf("r%0d_retire_cnt", e.ret), retire_cnt, e.ret);
                        check($sformatf("r%0d_branch_taken", e.ret), tk, e.tk);
                        check($sformatf("r%0d_exec_starts", e.ret), starts, e.starts);
                        check($sformatf("r%0d_instr", e.ret), instr, e.instr);
                    end
                    prev_ret = retire_cnt;
                    starts   = 0;
                    tk       = 1'b0;
                end
                if (branch_taken) tk = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    vec_t vecs[13];

    initial begin
        bit ok;
        int req_seen;
        int n;
        vec_t v;

        vecs = '{
            '{16'h0001, 16'h0005, 0, 2, 1'b0, 1'b0, 8'h01, 16'd1,  1'b0},
            '{16'h0000, 16'h0000, 1, 0, 1'b0, 1'b0, 8'h02, 16'd2,  1'b0},
            '{16'h0502, 16'h0000, 0, 0, 1'b0, 1'b0, 8'h50, 16'd3,  1'b1},
            '{16'h1234, 16'h0001, 0, 0, 1'b0, 1'b0, 8'h51, 16'd4,  1'b0},
            '{16'h0506, 16'h0000, 0, 0, 1'b0, 1'b0, 8'h50, 16'd5,  1'b1},
            '{16'h0003, 16'h0002, 0, 1, 1'b1, 1'b0, 8'h51, 16'd6,  1'b0},
            '{16'h0506, 16'h0000, 2, 0, 1'b1, 1'b0, 8'h52, 16'd7,  1'b0},
            '{16'h050A, 16'h0000, 0, 0, 1'b0, 1'b0, 8'h50, 16'd8,  1'b1},
            '{16'h050E, 16'h0000, 0, 0, 1'b0, 1'b0, 8'h51, 16'd9,  1'b0},
            '{16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0, 8'h52, 16'd10, 1'b0},
            '{16'h0FF2, 16'h0000, 0, 0, 1'b0, 1'b0, 8'hFF, 16'd11, 1'b1},
            '{16'h0001, 16'h0007, 0, 0, 1'b0, 1'b0, 8'h00, 16'd12, 1'b0},
            '{16'h0004, 16'h0009, 0, 2, 1'b0, 1'b1, 8'h01, 16'd13, 1'b0}
        };

        reset          = 1'b1;
        run            = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_data  = 16'h0000;
        bus.exec_done  = 1'b0;
        bus.alu_result = 16'h0000;
        repeat (2) @(negedge clk);
        run           = 1'b1;
        bus.imem_ack  = 1'b1;
        bus.exec_done = 1'b1;
        @(negedge clk);
        check("rst_pc", pc, 8'h00);
        check("rst_instr", instr, 16'h0000);
        check("rst_retire_cnt", retire_cnt, 16'h0000);
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_exec_start", bus.exec_start, 1'b0);
        check("rst_branch_taken", branch_taken, 1'b0);
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b0;
        reset         = 1'b0;
        mon_en        = 1'b1;

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            issue(v);
        end

        req_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.imem_req) req_seen++;
        end
        check("idle_after_run_drop", req_seen, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end

        run = 1'b1;
        wait_req(ok);
        if (!ok) timeout_fail("wait_imem_req_rst");
        bus.imem_ack  = 1'b1;
        bus.imem_data = 16'h0001;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'h0000;
        wait_start(ok);
        if (!ok) timeout_fail("wait_exec_start_rst");
        reset          = 1'b1;
        bus.exec_done  = 1'b1;
        bus.alu_result = 16'h1234;
        @(negedge clk);
        check("exec_rst_pc", pc, 8'h00);
        check("exec_rst_retire_cnt", retire_cnt, 16'h0000);
        check("exec_rst_instr", instr, 16'h0000);
        check("exec_rst_exec_start", bus.exec_start, 1'b0);
        reset         = 1'b0;
        bus.exec_done = 1'b0;
        run           = 1'b0;
        @(negedge clk);
        check("exec_rst_idle_req", bus.imem_req, 1'b0);
        run = 1'b1;
        v = '{16'h0502, 16'h0000, 0, 0, 1'b0, 1'b0, 8'h50, 16'd1, 1'b1};
        issue(v);
        run = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
